// File: rtl/aes_pkg.sv
// Shared AES round-datapath types and constants.
package aes_pkg;
   localparam int unsigned COL_BYTES = 4;
   localparam int unsigned IDX_W     = 2;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] col_t;
endpackage

// File: rtl/column_fifo2.sv
// Two-entry 32-bit synchronous FIFO with head-of-queue output.
module column_fifo2
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  col_t       push_data,
   input  logic       pop,
   output col_t       head,
   output logic [1:0] count
);

   col_t mem [2];
   logic rd_ptr;
   logic wr_ptr;

   // When full, wr_ptr aliases rd_ptr; a same-edge push+pop overwrites the slot being popped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/addroundkey_packer.sv
// Packs mixed bytes into 32-bit columns, XORs with the round key and buffers them for a valid/ready sink.
module addroundkey_packer
   import aes_pkg::*;
#(
   parameter int unsigned BYTES_PER_COL = COL_BYTES,
   parameter int unsigned FIFO_DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        key_load,
   input  logic [31:0] key_data,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic [7:0]  col_count
);

   logic [IDX_W-1:0] idx;
   logic [23:0]      col_lo;
   col_t             key;
   logic [1:0]       count;
   logic             last;
   logic             accept;
   logic             push;
   logic             pop;
   col_t             push_data;

   assign last      = (idx == IDX_W'(BYTES_PER_COL - 1));
   assign in_ready  = !last || (count < 2'(FIFO_DEPTH));
   assign accept    = in_valid && in_ready;
   assign push      = accept && last;
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;
   assign push_data = {in_data, col_lo} ^ key;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         col_lo    <= '0;
         key       <= '0;
         col_count <= '0;
      end else begin
         if (accept) begin
            if (!last) col_lo[8*idx +: 8] <= in_data;
            idx <= last ? '0 : idx + 1'b1;
         end
         if (key_load) key <= key_data;
         if (pop) col_count <= col_count + 8'd1;
      end
   end

   column_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (out_data),
      .count     (count)
   );

endmodule

// File: tb/tb_addroundkey_packer.sv
// Random and directed checks of addroundkey_packer against a queue-based column model.
module tb_addroundkey_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        key_load;
   logic [31:0] key_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic [7:0]  col_count;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  m_part [$];
   logic [31:0] m_fifo [$];
   logic [31:0] m_key;
   logic [7:0]  m_cnt;
   logic [31:0] dut_pops [$];

   addroundkey_packer #(.BYTES_PER_COL(4), .FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .key_load  (key_load),
      .key_data  (key_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .col_count (col_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready();
      return (m_part.size() != 3) || (m_fifo.size() < 2);
   endfunction

   // Inputs are already driven; advance model and DUT by one edge, then compare at negedge.
   task automatic step();
      logic rdy;
      logic [31:0] word;
      rdy = model_ready();
      if (!rst && out_valid && out_ready) dut_pops.push_back(out_data);
      @(posedge clk);
      if (rst) begin
         m_part.delete();
         m_fifo.delete();
         m_key = '0;
         m_cnt = '0;
      end else begin
         if (m_fifo.size() != 0 && out_ready) begin
            void'(m_fifo.pop_front());
            m_cnt++;
         end
         if (in_valid && rdy) begin
            if (m_part.size() == 3) begin
               word = {in_data, m_part[2], m_part[1], m_part[0]} ^ m_key;
               m_fifo.push_back(word);
               m_part.delete();
            end else begin
               m_part.push_back(in_data);
            end
         end
         if (key_load) m_key = key_data;
      end
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(model_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) chk("out_data", out_data, m_fifo[0]);
      chk("col_count", 32'(col_count), 32'(m_cnt));
   endtask

   task automatic idle(input logic rdy);
      in_valid = 1'b0; key_load = 1'b0; out_ready = rdy; rst = 1'b0;
      step();
   endtask

   task automatic send(input logic [7:0] b);
      int budget;
      budget = 20;
      in_valid = 1'b1; in_data = b; key_load = 1'b0;
      while (!model_ready() && budget > 0) begin
         step();
         budget--;
      end
      if (budget == 0) chk("send_timeout", 32'(0), 32'(1));
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1; in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < cycles; i++) step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; key_load = 1'b0;
      key_data = '0; out_ready = 1'b0;
      @(negedge clk);

      do_reset(2);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_col_count", 32'(col_count), 32'd0);

      out_ready = 1'b1;
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_data", out_data, 32'h44332211);
      idle(1'b1);
      chk("basic_count", 32'(col_count), 32'd1);

      key_load = 1'b1; key_data = 32'hFFFF0000; in_valid = 1'b0; step();
      key_load = 1'b0;
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("xor_data", out_data, 32'hFBFC0201);
      idle(1'b1);

      key_load = 1'b1; key_data = 32'h000000FF; step();
      key_load = 1'b0;
      send(8'h00); send(8'h00); send(8'h00);
      in_valid = 1'b1; in_data = 8'h00; key_load = 1'b1; key_data = 32'h0000FF00; step();
      in_valid = 1'b0; key_load = 1'b0;
      chk("collide_old_key", out_data, 32'h000000FF);
      idle(1'b1);
      send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      chk("collide_new_key", out_data, 32'h0000FF00);
      idle(1'b1);

      do_reset(1);
      out_ready = 1'b0;
      for (int i = 1; i <= 11; i++) send(8'(i));
      chk("bp_stall", 32'(in_ready), 32'd0);
      in_valid = 1'b1; in_data = 8'h0C;
      step(); step();
      chk("bp_still_stalled", 32'(in_ready), 32'd0);
      dut_pops.delete();
      out_ready = 1'b1;
      send(8'h0C);
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("bp_pops", 32'(dut_pops.size()), 32'd3);
      if (dut_pops.size() == 3) begin
         chk("bp_pop_a", dut_pops[0], 32'h04030201);
         chk("bp_pop_b", dut_pops[1], 32'h08070605);
         chk("bp_pop_c", dut_pops[2], 32'h0C0B0A09);
      end
      chk("bp_count", 32'(col_count), 32'd3);

      out_ready = 1'b1;
      send(8'hAA); send(8'hBB);
      do_reset(1);
      key_load = 1'b1; key_data = 32'h0; step(); key_load = 1'b0;
      out_ready = 1'b1;
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("midrst_data", out_data, 32'h04030201);
      idle(1'b1);

      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         key_load  = ($urandom_range(0, 9) == 0);
         key_data  = $urandom;
         out_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/addroundkey_packer.md
# addroundkey_packer

Downstream neighbour of the byte-wide `mixcolumn` stage. It accepts the stream of mixed bytes, packs each group of four into a 32-bit column, and XORs the column with a loadable 32-bit round-key word (AddRoundKey). Finished columns go out through a 2-entry buffer with a valid/ready handshake, so the round datapath can stall without losing data.

## Interface
- `BYTES_PER_COL`, default 4: bytes packed per column; the only supported value is 4.
- `FIFO_DEPTH`, default 2: output buffer depth in columns; the only supported value is 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  `in_data` holds a mixed byte.
- `in_data`  in  8  mixed byte from the upstream stage.
- `in_ready`  out  1  byte is accepted on `in_valid && in_ready`.
- `key_load`  in  1  load `key_data` into the round-key register.
- `key_data`  in  32  round-key word.
- `out_valid`  out  1  `out_data` holds a finished column.
- `out_data`  out  32  column XOR key.
- `out_ready`  in  1  column is popped on `out_valid && out_ready`.
- `col_count`  out  8  number of columns popped, modulo 256.

## Operation
- **Byte index.** `idx` is a 2-bit counter, 0..3.
  - On each accepted byte it stores the byte into `col[8*idx +: 8]` and increments, wrapping 3 -> 0.
  - Byte 0 lands in `out_data[7:0]`, byte 3 in `out_data[31:24]`.
- **Column completion.** Accepting a byte while `idx==3` completes a column.
  - The pushed word is `{in_data, col[23:0]} ^ key`.
  - `key` is the register value before this edge.
- **Key register.**
  - Reset value is 0.
  - `key_load` updates it at the edge.
  - If `key_load` coincides with a completion, the completing column uses the old key and the new key applies from the next column.
- **Output buffer.** 2-entry FIFO, strict order.
  - `out_valid = (count != 0)`.
  - `out_data` shows the head entry and is stable while `out_valid && !out_ready`.
- **Simultaneous push and pop.**
  - Allowed at any count.
  - At count 2, a pop plus a push leaves count at 2. No overflow occurs, because `in_ready` already excluded the push unless the buffer had room.
- **Ready rule.** `in_ready = (idx != 3) || (count < 2)`.
  - Registered terms only; no combinational path from `out_ready`.
  - Bytes 0..2 are always accepted; only the completing byte can stall.
- **Pop counter.** `col_count` increments on every pop and wraps 255 -> 0.
- **Reset.** Clears `idx`, the partial column, `key`, the FIFO and `col_count`.
  - A reset in the middle of a column discards the partial bytes.
  - Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `col_count=0`.
- **Input hold.** `in_data` changes while `in_valid && !in_ready` are tolerated; only the value sampled on acceptance matters.

## Timing
- Latency: completing byte accepted at edge N, with an empty FIFO -> `out_valid=1` with the column during cycle N+1. One cycle, registered.
- Throughput: one column per 4 accepted bytes. With `out_ready` held high the buffer never fills.
- Backpressure:
  - With `out_ready` low, two columns are buffered.
  - The third column's byte 3 sees `in_ready=0` until one cycle after the first pop.
  - Bytes 0..2 of the third column are still accepted before that.
- `key_load` takes effect for columns completed at edge N+1 or later.
- `col_count` updates at the pop edge and is visible the next cycle.

## Structure
- Shared package `aes_pkg`:
  - `BYTES_PER_COL` and the index width (2).
  - `col_t` (32-bit column type).
  - `byte_t`.
- Sub-module `column_fifo2`: 2-entry, 32-bit synchronous FIFO with `push`, `pop`, `count`, head output and synchronous reset.
- The top level holds the index counter, partial-column register, key register, XOR, ready logic and pop counter.

## Test plan
- **Reset:** assert `rst` for 2 cycles -> `in_ready=1`, `out_valid=0`, `out_data=0`, `col_count=0`.
- **Basic pack:** key 0, bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `out_ready=1` -> one cycle after 0x44, `out_valid=1`, `out_data=0x44332211`; then `col_count=1`.
- **Key XOR:** `key_load` with 0xFFFF0000, then bytes 01, 02, 03, 04 -> `out_data=0xFBFC0201`.
- **Key/completion collision:** key 0x000000FF loaded earlier; `key_load` 0x0000FF00 in the same cycle as byte 3 of column 00 00 00 00 -> `out_data=0x000000FF`; the next all-zero column gives 0x0000FF00.
- **Backpressure:** `out_ready=0`, stream 12 bytes (columns A, B, C) -> 8 bytes accepted, C's bytes 0..2 accepted, `in_ready=0` at C byte 3; raise `out_ready` -> pops in order A, B, C with no loss or duplication; `col_count=3`.
- **Reset mid-column:** accept 0xAA, 0xBB, assert `rst`, then send 01, 02, 03, 04 with key reloaded to 0 -> `out_data=0x04030201`; no 0xAA or 0xBB appears.
